mem_byte_ctrl: RTL and testbench

Memory-stage controller at the receiving end of the execute stage's memory request bus (`ex_mem_e` / `ex_mem_n` / `res`). It turns each load/store request into a byte-serial sequence on the 8-bit unified RAM port and sign- or zero-extends load results. It holds the pipeline via `stall_req` until the access completes, then hands the write-back triple (`wa_o`, `we_o`, `wn_o`) to the write-back stage. Non-memory instructions pass through with one register stage.

---
 rtl/mem_byte_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_byte_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl: memory-stage controller that serialises load/store requests onto an
// 8-bit RAM port, sign/zero-extends loads and stalls the pipeline until the access retires.
// Optional feature macro: MEM_MISALIGN_CHK_EN (trap misaligned half/word requests).
module mem_byte_ctrl #(
    parameter int unsigned BYTE_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             ex_mem_e,
    input  logic [31:0]            ex_mem_n,
    input  logic [31:0]            res,
    input  logic [4:0]             wa_i,
    input  logic                   we_i,
    input  logic [7:0]             mem_din,
    output logic [BYTE_ADDR_W-1:0] mem_a,
    output logic [7:0]             mem_dout,
    output logic                   mem_wr,
    output logic                   stall_req,
    output logic [4:0]             wa_o,
    output logic                   we_o,
    output logic [31:0]            wn_o,
    output logic                   done,
    output logic                   misalign
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e                 state, state_next;
    logic [1:0]             cnt;
    logic [1:0]             cnt_prev;
    logic [BYTE_ADDR_W-1:0] addr;
    logic [31:0]            data;
    logic [1:0]             len;
    logic                   wr;
    logic                   uns;
    logic [4:0]             wa_cap;
    logic                   we_cap;

    logic                   req_en;
    logic [1:0]             req_len;
    logic                   req_mis;
    logic [BYTE_ADDR_W-1:0] req_addr;
    logic [31:0]            req_word;
    logic [31:0]            addr_word;
    logic [1:0]             last_idx;
    logic [31:0]            load_word;
    logic [31:0]            load_ext;

    assign req_en  = ex_mem_e[4];
    assign req_len = ex_mem_e[3:2];

    // Address as seen on the RAM port and as returned in wn_o for stores/traps.
    generate
        if (BYTE_ADDR_W >= 32) begin : g_wide_addr
            assign req_addr  = BYTE_ADDR_W'(res);
            assign req_word  = res;
            assign addr_word = addr[31:0];
        end else begin : g_narrow_addr
            assign req_addr  = res[BYTE_ADDR_W-1:0];
            assign req_word  = 32'(res[BYTE_ADDR_W-1:0]);
            assign addr_word = 32'(addr);
        end
    endgenerate

`ifdef MEM_MISALIGN_CHK_EN
    logic mis_flag;

    // len 2 is handled as a word, so it takes the word alignment rule.
    assign req_mis = ((req_len == 2'd1) && res[0]) || (req_len[1] && (res[1:0] != 2'b00));

    // Remember whether the DONE we are heading into is a trap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_flag <= 1'b0;
        end else if (state == StIdle) begin
            mis_flag <= req_en && req_mis;
        end
    end

    assign misalign = (state == StDone) && mis_flag;
`else
    assign req_mis  = 1'b0;
    assign misalign = 1'b0;
`endif

    // Index of the final byte: len 0 -> 1 byte, 1 -> 2 bytes, 2/3 -> 4 bytes.
    assign last_idx = (len == 2'd0) ? 2'd0 : (len == 2'd1) ? 2'd1 : 2'd3;
    assign cnt_prev = cnt - 2'd1;

    // RAM port and handshake outputs are decoded from state so reset kills them at once.
    always_comb begin
        mem_a     = '0;
        mem_dout  = 8'h00;
        mem_wr    = 1'b0;
        if (state == StAccess) begin
            mem_a = addr + BYTE_ADDR_W'(cnt);
            if (wr) begin
                mem_dout = data[{cnt, 3'b000} +: 8];
                mem_wr   = 1'b1;
            end
        end
        stall_req = (state == StAccess) || (state == StWait) || ((state == StIdle) && req_en);
        done      = (state == StDone);
    end

    // Merge the final byte arriving this cycle and extend to 32 bits.
    always_comb begin
        load_word = data;
        load_word[{last_idx, 3'b000} +: 8] = mem_din;
        case (len)
            2'd0:    load_ext = {{24{load_word[7] & ~uns}}, load_word[7:0]};
            2'd1:    load_ext = {{16{load_word[15] & ~uns}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            StIdle: begin
                if (req_en) begin
                    state_next = req_mis ? StDone : StAccess;
                end
            end
            StAccess: begin
                if (cnt == last_idx) begin
                    state_next = wr ? StDone : StWait;
                end
            end
            StWait:  state_next = StDone;
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Request capture, byte counter, load assembly and write-back registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            addr   <= '0;
            data   <= '0;
            len    <= '0;
            wr     <= 1'b0;
            uns    <= 1'b0;
            wa_cap <= '0;
            we_cap <= 1'b0;
            wa_o   <= '0;
            we_o   <= 1'b0;
            wn_o   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (!req_en) begin
                        wa_o <= wa_i;
                        we_o <= we_i;
                        wn_o <= res;
                    end else begin
                        cnt    <= '0;
                        addr   <= req_addr;
                        data   <= ex_mem_n;
                        len    <= req_len;
                        wr     <= ex_mem_e[1];
                        uns    <= ex_mem_e[0];
                        wa_cap <= wa_i;
                        we_cap <= we_i;
                        we_o   <= 1'b0;
                        if (req_mis) begin
                            wa_o <= wa_i;
                            wn_o <= req_word;
                        end
                    end
                end
                StAccess: begin
                    cnt <= cnt + 2'd1;
                    // Read data lags its address by one cycle.
                    if (!wr && (cnt != 2'd0)) begin
                        data[{cnt_prev, 3'b000} +: 8] <= mem_din;
                    end
                    if (wr && (cnt == last_idx)) begin
                        wa_o <= wa_cap;
                        we_o <= 1'b0;
                        wn_o <= addr_word;
                    end
                end
                StWait: begin
                    wa_o <= wa_cap;
                    we_o <= we_cap;
                    wn_o <= load_ext;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Self-checking bench for mem_byte_ctrl: directed scenarios plus randomized traffic checked
// against a byte-array memory model and arithmetic latency/extension rules.
module tb_mem_byte_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ex_mem_e = '0;
    logic [31:0] ex_mem_n = '0;
    logic [31:0] res = '0;
    logic [4:0]  wa_i = '0;
    logic        we_i = 1'b0;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        stall_req;
    logic [4:0]  wa_o;
    logic        we_o;
    logic [31:0] wn_o;
    logic        done;
    logic        misalign;

    logic        ram_clr = 1'b1;
    logic [7:0]  ram [0:1023];
    logic [7:0]  exp_mem [0:1023];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_byte_ctrl #(.BYTE_ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_mem_e  (ex_mem_e),
        .ex_mem_n  (ex_mem_n),
        .res       (res),
        .wa_i      (wa_i),
        .we_i      (we_i),
        .mem_din   (mem_din),
        .mem_a     (mem_a),
        .mem_dout  (mem_dout),
        .mem_wr    (mem_wr),
        .stall_req (stall_req),
        .wa_o      (wa_o),
        .we_o      (we_o),
        .wn_o      (wn_o),
        .done      (done),
        .misalign  (misalign)
    );

    // RAM seen by the DUT: synchronous write, read data one cycle after its address.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
        end else if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    function automatic int nbytes(input logic [1:0] l);
        return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input logic [1:0] l, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHK_EN
        return ((l == 2'd1) && a[0]) || ((l >= 2'd2) && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] l, input logic u,
                                             input logic [31:0] a);
        int          n;
        logic [31:0] v;
        logic [31:0] ba;
        n = nbytes(l);
        v = '0;
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(k);
            v  = v | (32'(exp_mem[ba[9:0]]) << (8 * k));
        end
        if (!u && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] l, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ba;
        for (int k = 0; k < nbytes(l); k++) begin
            ba = a + 32'(k);
            exp_mem[ba[9:0]] = d[8*k +: 8];
        end
    endtask

    // Issues one request in cycle A (c = 0) and observes it until done or a cycle budget.
    task automatic run_mem(input logic wr, input logic [1:0] len, input logic uns,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] wa, input logic we,
                           output int lat, output logic bus_ok, output logic hold_ok,
                           output logic [31:0] wn, output logic [4:0] wa_g,
                           output logic we_g, output logic mis_g);
        int          n;
        logic        m;
        logic [31:0] ea;
        n = nbytes(len);
        m = is_mis(len, addr);
        @(posedge clk);
        #1;
        ex_mem_e = {1'b1, len, wr, uns};
        res      = addr;
        ex_mem_n = data;
        wa_i     = wa;
        we_i     = we;
        lat = -1; bus_ok = 1'b1; hold_ok = 1'b1;
        wn = '0; wa_g = '0; we_g = 1'b0; mis_g = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!m && (c >= 1) && (c <= n)) begin
                ea = addr + 32'(c - 1);
                if ((mem_a !== ea) || (mem_wr !== wr)) bus_ok = 1'b0;
                if (wr && (mem_dout !== data[8*(c-1) +: 8])) bus_ok = 1'b0;
            end else if (mem_wr !== 1'b0) begin
                bus_ok = 1'b0;
            end
            if (done === 1'b1) begin
                lat   = c;
                if (stall_req !== 1'b0) hold_ok = 1'b0;
                wn    = wn_o;
                wa_g  = wa_o;
                we_g  = we_o;
                mis_g = misalign;
                break;
            end
            if (stall_req !== 1'b1) hold_ok = 1'b0;
            if ((c >= 1) && (we_o !== 1'b0)) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) exp_mem[i] = 8'h00;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({mem_a, mem_dout, mem_wr, wa_o, we_o, wn_o, done, misalign} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got a=%h dout=%h wr=%b wa=%h we=%b wn=%h done=%b mis=%b, exp all 0",
                     mem_a, mem_dout, mem_wr, wa_o, we_o, wn_o, done, misalign);
        end
        n_vec++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall: got %b exp 0", stall_req);
        end
        ram_clr = 1'b0;
        rst     = 1'b1;
    endtask

    task automatic test_store_word();
        int lat; logic bok, hok, we_g, mis_g; logic [31:0] wn; logic [4:0] wa_g;
        run_mem(1'b1, 2'd3, 1'b0, 32'h100, 32'hDEAD_BEEF, 5'd3, 1'b1,
                lat, bok, hok, wn, wa_g, we_g, mis_g);
        ref_store(2'd3, 32'h100, 32'hDEAD_BEEF);
        n_vec++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL sw_latency: got %0d exp 5", lat);
        end
        n_vec++;
        if (bok !== 1'b1) begin
            n_err++;
            $display("FAIL sw_bus: got %b exp 1", bok);
        end
        n_vec++;
        if (hok !== 1'b1) begin
            n_err++;
            $display("FAIL sw_stall: got %b exp 1", hok);
        end
        n_vec++;
        if ((wn !== 32'h100) || (we_g !== 1'b0) || (wa_g !== 5'd3)) begin
            n_err++;
            $display("FAIL sw_wb: got wn=%h we=%b wa=%h exp wn=00000100 we=0 wa=03",
                     wn, we_g, wa_g);
        end
    endtask

    task automatic test_load_byte();
        int lat; logic bok, hok, we_g, mis_g; logic [31:0] wn; logic [4:0] wa_g;
        run_mem(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1,
                lat, bok, hok, wn, wa_g, we_g, mis_g);
        n_vec++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL lb_latency: got %0d exp 3", lat);
        end
        n_vec++;
        if (wn !== 32'hFFFF_FFEF) begin
            n_err++;
            $display("FAIL lb_signed: got %h exp ffffffef", wn);
        end
        n_vec++;
        if ((we_g !== 1'b1) || (wa_g !== 5'd7) || (bok !== 1'b1) || (hok !== 1'b1)) begin
            n_err++;
            $display("FAIL lb_ctrl: got we=%b wa=%h bus=%b hold=%b exp 1 07 1 1",
                     we_g, wa_g, bok, hok);
        end
        run_mem(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 5'd8, 1'b0,
                lat, bok, hok, wn, wa_g, we_g, mis_g);
        n_vec++;
        if (wn !== 32'h0000_00EF) begin
            n_err++;
            $display("FAIL lbu_zero: got %h exp 000000ef", wn);
        end
        n_vec++;
        if (we_g !== 1'b0) begin
            n_err++;
            $display("FAIL lbu_we: got %b exp 0", we_g);
        end
    endtask

    task automatic test_load_half();
        int lat; logic bok, hok, we_g, mis_g; logic [31:0] wn; logic [4:0] wa_g;
        run_mem(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd9, 1'b1,
                lat, bok, hok, wn, wa_g, we_g, mis_g);
        n_vec++;
        if (wn !== 32'hFFFF_DEAD) begin
            n_err++;
            $display("FAIL lh_value: got %h exp ffffdead", wn);
        end
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL lh_latency: got %0d exp 4", lat);
        end
        n_vec++;
        if ((hok !== 1'b1) || (bok !== 1'b1)) begin
            n_err++;
            $display("FAIL lh_stall_bus: got hold=%b bus=%b exp 1 1", hok, bok);
        end
        n_vec++;
        if (we_g !== 1'b1) begin
            n_err++;
            $display("FAIL lh_we: got %b exp 1", we_g);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [0:2];
        vals[0] = 32'd5; vals[1] = 32'd6; vals[2] = 32'd7;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) begin
                ex_mem_e = 5'b0_1101;
                res      = vals[i];
                wa_i     = 5'(i + 1);
                we_i     = i[0];
            end
            @(negedge clk);
            n_vec++;
            if (stall_req !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_stall[%0d]: got %b exp 0", i, stall_req);
            end
            if (i > 0) begin
                n_vec++;
                if ((wn_o !== vals[i-1]) || (wa_o !== 5'(i)) || (we_o !== i[0] ^ 1'b1)) begin
                    n_err++;
                    $display("FAIL b2b_pass[%0d]: got wn=%h wa=%h we=%b exp wn=%h wa=%h we=%b",
                             i, wn_o, wa_o, we_o, vals[i-1], 5'(i), i[0] ^ 1'b1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int lat; logic bok, hok, we_g, mis_g; logic [31:0] wn, exp_wn; logic [4:0] wa_g;
        @(posedge clk);
        #1;
        ex_mem_e = {1'b1, 2'd3, 1'b1, 1'b0};
        res      = 32'h300;
        ex_mem_n = 32'h1234_5678;
        wa_i     = 5'd4;
        we_i     = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if ((mem_wr !== 1'b1) || (mem_a !== 32'h302)) begin
            n_err++;
            $display("FAIL rst_mid_pre: got wr=%b a=%h exp 1 00000302", mem_wr, mem_a);
        end
        rst      = 1'b0;
        ex_mem_e = '0;
        #1;
        n_vec++;
        if (mem_wr !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_wr: got %b exp 0", mem_wr);
        end
        n_vec++;
        if ({mem_a, mem_dout, wa_o, we_o, wn_o, done, misalign, stall_req} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outs: got a=%h dout=%h wa=%h we=%b wn=%h done=%b stall=%b",
                     mem_a, mem_dout, wa_o, we_o, wn_o, done, stall_req);
        end
        exp_mem[10'h300] = 8'h78;
        exp_mem[10'h301] = 8'h56;
        @(negedge clk);
        rst = 1'b1;
        exp_wn = ref_load(2'd3, 1'b0, 32'h300);
        run_mem(1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 5'd5, 1'b1,
                lat, bok, hok, wn, wa_g, we_g, mis_g);
        n_vec++;
        if (wn !== exp_wn) begin
            n_err++;
            $display("FAIL rst_mid_partial: got %h exp %h", wn, exp_wn);
        end
    endtask

`ifdef MEM_MISALIGN_CHK_EN
    task automatic test_misalign();
        int lat; logic bok, hok, we_g, mis_g; logic [31:0] wn; logic [4:0] wa_g;
        run_mem(1'b0, 2'd3, 1'b0, 32'h101, 32'h0, 5'd6, 1'b1,
                lat, bok, hok, wn, wa_g, we_g, mis_g);
        n_vec++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL mis_latency: got %0d exp 1", lat);
        end
        n_vec++;
        if ((mis_g !== 1'b1) || (we_g !== 1'b0) || (wn !== 32'h101) || (bok !== 1'b1)) begin
            n_err++;
            $display("FAIL mis_out: got mis=%b we=%b wn=%h bus=%b exp 1 0 00000101 1",
                     mis_g, we_g, wn, bok);
        end
    endtask
`endif

    task automatic test_random();
        int lat, exp_lat, n;
        logic bok, hok, we_g, mis_g, wr, uns, we, m, exp_we;
        logic [31:0] wn, addr, data, exp_wn, pr;
        logic [4:0]  wa_g, wa;
        logic [1:0]  len;
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                @(posedge clk);
                #1;
                pr       = $urandom;
                ex_mem_e = {1'b0, 4'($urandom)};
                res      = pr;
                wa_i     = 5'($urandom);
                we_i     = 1'($urandom);
                @(negedge clk);
                @(negedge clk);
                n_vec++;
                if ((wn_o !== pr) || (stall_req !== 1'b0)) begin
                    n_err++;
                    $display("FAIL rnd_pass[%0d]: got wn=%h stall=%b exp wn=%h stall=0",
                             it, wn_o, stall_req, pr);
                end
            end
            wr   = 1'($urandom);
            len  = 2'($urandom);
            uns  = 1'($urandom);
            data = $urandom;
            wa   = 5'($urandom);
            we   = 1'($urandom);
            addr = 32'h200 + 32'($urandom_range(0, 60));
            if (it == 0) begin wr = 1'b1; len = 2'd3; addr = 32'hFFFF_FFFE; end
            if (it == 1) begin wr = 1'b0; len = 2'd3; addr = 32'hFFFF_FFFE; end
            n       = nbytes(len);
            m       = is_mis(len, addr);
            exp_lat = m ? 1 : (wr ? n + 1 : n + 2);
            exp_wn  = (m || wr) ? addr : ref_load(len, uns, addr);
            exp_we  = (m || wr) ? 1'b0 : we;
            run_mem(wr, len, uns, addr, data, wa, we, lat, bok, hok, wn, wa_g, we_g, mis_g);
            if (wr && !m) ref_store(len, addr, data);
            n_vec++;
            if (lat !== exp_lat) begin
                n_err++;
                $display("FAIL rnd_latency[%0d]: got %0d exp %0d", it, lat, exp_lat);
            end
            n_vec++;
            if (bok !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_bus[%0d]: got %b exp 1", it, bok);
            end
            n_vec++;
            if (hok !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_hold[%0d]: got %b exp 1", it, hok);
            end
            n_vec++;
            if (wn !== exp_wn) begin
                n_err++;
                $display("FAIL rnd_wn[%0d]: got %h exp %h", it, wn, exp_wn);
            end
            n_vec++;
            if ((we_g !== exp_we) || (wa_g !== wa)) begin
                n_err++;
                $display("FAIL rnd_wb[%0d]: got we=%b wa=%h exp we=%b wa=%h",
                         it, we_g, wa_g, exp_we, wa);
            end
            n_vec++;
            if (mis_g !== m) begin
                n_err++;
                $display("FAIL rnd_misalign[%0d]: got %b exp %b", it, mis_g, m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half();
        test_back_to_back();
        test_reset_mid_access();
`ifdef MEM_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
